// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse stream-mode packet decoder with clamped cursor tracking.
// Define MOUSE_WHEEL_EN for 4-byte wheel packets (3-byte by default).
module mouse_packet_decoder #(
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int POS_W          = 10,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       received_data,
    input  logic             received_data_en,
    input  logic             stream_enable,
    output logic             packet_valid,
    output logic [2:0]       buttons,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic [3:0]       wheel,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             sync_error
);

    localparam int SW = POS_W + 2;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [SW-1:0] XM = SW'(X_MAX);
    localparam logic signed [SW-1:0] YM = SW'(Y_MAX);

    typedef enum logic [2:0] {
        B0,
        B1,
        B2,
`ifdef MOUSE_WHEEL_EN
        B3,
`endif
        UPD
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [3:0]             hflag;
    logic [2:0]             hbtn;
    logic [7:0]             xb;
`ifdef MOUSE_WHEEL_EN
    logic [7:0]             yb;
`endif
    logic [7:0]             yfin;
    logic [8:0]             dx_n;
    logic [8:0]             dy_n;
    logic signed [SW-1:0]   sx;
    logic signed [SW-1:0]   sy;
    logic [POS_W-1:0]       px_n;
    logic [POS_W-1:0]       py_n;
    logic                   timeout;

    // hflag holds header bits [7:4]: {y_ovf, x_ovf, y_sign, x_sign}
    always_comb begin
`ifdef MOUSE_WHEEL_EN
        yfin = yb;
`else
        yfin = received_data;
`endif
        dx_n = hflag[2] ? 9'd0 : {hflag[0], xb};
        dy_n = hflag[3] ? 9'd0 : {hflag[1], yfin};
        sx = $signed({2'b00, pos_x}) + $signed({{(SW-9){dx_n[8]}}, dx_n});
        sy = $signed({2'b00, pos_y}) - $signed({{(SW-9){dy_n[8]}}, dy_n});
        if (sx < 0)
            px_n = '0;
        else if (sx > XM)
            px_n = POS_W'(X_MAX);
        else
            px_n = sx[POS_W-1:0];
        if (sy < 0)
            py_n = '0;
        else if (sy > YM)
            py_n = POS_W'(Y_MAX);
        else
            py_n = sy[POS_W-1:0];
        timeout = (cnt == CW'(TIMEOUT_CYCLES));
    end

`ifndef MOUSE_WHEEL_EN
    assign wheel = 4'h0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= B0;
            cnt          <= '0;
            hflag        <= '0;
            hbtn         <= '0;
            xb           <= '0;
`ifdef MOUSE_WHEEL_EN
            yb           <= '0;
            wheel        <= '0;
`endif
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            buttons      <= '0;
            dx           <= '0;
            dy           <= '0;
            pos_x        <= POS_W'(X_MAX / 2);
            pos_y        <= POS_W'(Y_MAX / 2);
        end else begin
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            if (!stream_enable) begin
                state <= B0;
                cnt   <= '0;
            end else if (state == B0 || state == UPD) begin
                state <= B0;
                cnt   <= '0;
                if (received_data_en) begin
                    if (received_data[3]) begin
                        hflag <= received_data[7:4];
                        hbtn  <= received_data[2:0];
                        state <= B1;
                    end else begin
                        sync_error <= 1'b1;
                    end
                end
            end else if (!received_data_en) begin
                if (timeout) begin
                    state      <= B0;
                    cnt        <= '0;
                    sync_error <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                // a byte arriving on the timeout cycle is still accepted
                cnt <= '0;
                unique case (state)
                    B1: begin
                        xb    <= received_data;
                        state <= B2;
                    end
                    B2: begin
`ifdef MOUSE_WHEEL_EN
                        yb    <= received_data;
                        state <= B3;
`else
                        buttons      <= hbtn;
                        dx           <= dx_n;
                        dy           <= dy_n;
                        pos_x        <= px_n;
                        pos_y        <= py_n;
                        packet_valid <= 1'b1;
                        state        <= UPD;
`endif
                    end
`ifdef MOUSE_WHEEL_EN
                    B3: begin
                        wheel        <= received_data[3:0];
                        buttons      <= hbtn;
                        dx           <= dx_n;
                        dy           <= dy_n;
                        pos_x        <= px_n;
                        pos_y        <= py_n;
                        packet_valid <= 1'b1;
                        state        <= UPD;
                    end
`endif
                    default: state <= B0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed plus randomized bench for mouse_packet_decoder.
// Expected cursor and deltas come from an integer model of the packet rules.
module tb_mouse_packet_decoder;

    localparam int XM = 639;
    localparam int YM = 479;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       stream_enable;
    logic       packet_valid;
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] wheel;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       sync_error;

    mouse_packet_decoder #(
        .X_MAX(XM),
        .Y_MAX(YM),
        .POS_W(10),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .received_data(received_data),
        .received_data_en(received_data_en),
        .stream_enable(stream_enable),
        .packet_valid(packet_valid),
        .buttons(buttons),
        .dx(dx),
        .dy(dy),
        .wheel(wheel),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int pv_cnt = 0;
    int se_cnt = 0;
    int both_cnt = 0;

    int ex_x;
    int ex_y;
    logic [2:0] ex_b;
    logic [8:0] ex_dx;
    logic [8:0] ex_dy;
    logic [3:0] ex_w;

    int s_pv;
    int s_se;
    logic found;
    logic [7:0] h;
    logic [7:0] g;

    always @(posedge clk) begin
        if (packet_valid) pv_cnt++;
        if (sync_error) se_cnt++;
        if (packet_valid && sync_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".buttons"}, 32'(buttons), 32'(ex_b));
        check({tag, ".dx"}, 32'(dx), 32'(ex_dx));
        check({tag, ".dy"}, 32'(dy), 32'(ex_dy));
        check({tag, ".wheel"}, 32'(wheel), 32'(ex_w));
        check({tag, ".pos_x"}, 32'(pos_x), 32'(ex_x));
        check({tag, ".pos_y"}, 32'(pos_y), 32'(ex_y));
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model(input logic [7:0] hb, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] w);
        int mdx;
        int mdy;
        mdx = hb[6] ? 0 : (hb[4] ? int'(x) - 256 : int'(x));
        mdy = hb[7] ? 0 : (hb[5] ? int'(y) - 256 : int'(y));
        ex_x  = clampi(ex_x + mdx, XM);
        ex_y  = clampi(ex_y - mdy, YM);
        ex_b  = hb[2:0];
        ex_dx = 9'(mdx);
        ex_dy = 9'(mdy);
`ifdef MOUSE_WHEEL_EN
        ex_w  = w[3:0];
`else
        ex_w  = 4'h0;
        if (w == 8'hA5) ex_w = 4'h0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] hb,
                            input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input int gap);
        send_byte(hb, gap);
        send_byte(x, gap);
        send_byte(y, gap);
`ifdef MOUSE_WHEEL_EN
        send_byte(w, gap);
`endif
        model(hb, x, y, w);
        check({tag, ".pv"}, 32'(packet_valid), 32'd1);
        check({tag, ".se"}, 32'(sync_error), 32'd0);
        check_out(tag);
        @(negedge clk);
        check({tag, ".pv_end"}, 32'(packet_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        stream_enable    = 1'b1;
        repeat (3) @(negedge clk);
        ex_x  = XM / 2;
        ex_y  = YM / 2;
        ex_b  = 3'b000;
        ex_dx = 9'd0;
        ex_dy = 9'd0;
        ex_w  = 4'h0;
        check("rst.pv", 32'(packet_valid), 32'd0);
        check("rst.se", 32'(sync_error), 32'd0);
        check_out("rst");
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        do_reset();

        send_pkt("t1", 8'h09, 8'h10, 8'h00, 8'h00, 0);
        check("t1.x335", 32'(pos_x), 32'd335);
        send_pkt("t2", 8'h28, 8'h00, 8'hF0, 8'h00, 1);
        check("t2.y255", 32'(pos_y), 32'd255);
        check("t2.dy", 32'(dy), 32'h1F0);

        do_reset();
        send_pkt("t3a", 8'h18, 8'h00, 8'h00, 8'h00, 0);
        check("t3a.x63", 32'(pos_x), 32'd63);
        send_pkt("t3b", 8'h18, 8'h00, 8'h00, 8'h00, 0);
        check("t3b.x0", 32'(pos_x), 32'd0);
        send_pkt("t3c", 8'h08, 8'hFF, 8'h00, 8'h00, 0);
        check("t3c.x255", 32'(pos_x), 32'd255);
        send_pkt("t3d", 8'h08, 8'hFF, 8'h00, 8'h00, 0);
        check("t3d.x510", 32'(pos_x), 32'd510);
        send_pkt("t3e", 8'h08, 8'hFF, 8'h00, 8'h00, 0);
        check("t3e.x639", 32'(pos_x), 32'd639);

        send_byte(8'h00, 0);
        check("t4.se", 32'(sync_error), 32'd1);
        check("t4.nopv", 32'(packet_valid), 32'd0);
        @(negedge clk);
        check("t4.se_end", 32'(sync_error), 32'd0);
        send_pkt("t4", 8'h08, 8'h01, 8'h01, 8'h00, 0);

        s_pv = pv_cnt;
        send_byte(8'h08, 0);
        send_byte(8'h05, 0);
        found = 1'b0;
        for (int i = 0; i < TO + 20 && !found; i++) begin
            @(negedge clk);
            if (sync_error) found = 1'b1;
        end
        check("t5.timeout", 32'(found), 32'd1);
        check("t5.nopv", 32'(pv_cnt - s_pv), 32'd0);
        check_out("t5.hold");
        send_pkt("t5", 8'h08, 8'h02, 8'h00, 8'h00, 0);
        check("t5.dx2", 32'(dx), 32'd2);

        s_pv = pv_cnt;
        s_se = se_cnt;
        send_byte(8'h08, 0);
        stream_enable = 1'b0;
        @(negedge clk);
        send_byte(8'h00, 0);
        stream_enable = 1'b1;
        @(negedge clk);
        check("t5s.nopv", 32'(pv_cnt - s_pv), 32'd0);
        check("t5s.nose", 32'(se_cnt - s_se), 32'd0);
        check_out("t5s.hold");
        send_pkt("t5s", 8'h08, 8'h03, 8'h00, 8'h00, 0);

        send_pkt("t6", 8'h48, 8'hFF, 8'h10, 8'h0F, 0);
        check("t6.dx0", 32'(dx), 32'd0);
        check("t6.dy16", 32'(dy), 32'd16);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                g = 8'($urandom) & 8'hF7;
                send_byte(g, $urandom_range(0, 3));
                check("rnd.se", 32'(sync_error), 32'd1);
                check("rnd.se_nopv", 32'(packet_valid), 32'd0);
            end
            h = 8'($urandom) | 8'h08;
            h[6] = ($urandom_range(0, 7) == 0);
            h[7] = ($urandom_range(0, 7) == 0);
            send_pkt("rnd", h, 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 4));
        end

        check("never_both", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
